// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder types: Q8.8 LLR word, magnitude type, saturating absolute value.
package ldpc_pkg;
    localparam int INT  = 8;
    localparam int FRAC = 8;
    localparam int W    = INT + FRAC;

    typedef logic signed [W-1:0] llr_t;
    typedef logic        [W-1:0] mag_t;

    localparam mag_t MAG_MAX    = {1'b0, {(W-1){1'b1}}};
    localparam llr_t LLR_MIN    = {1'b1, {(W-1){1'b0}}};
    localparam mag_t OFFSET_DEF = mag_t'(128);

    // The most negative LLR has no positive twin, so it clamps to MAG_MAX.
    function automatic mag_t sat_abs(input llr_t x);
        mag_t r;
        r = mag_t'(x);
        if (x[W-1]) begin
            r = (x == LLR_MIN) ? MAG_MAX : mag_t'(-x);
        end
        return r;
    endfunction
endpackage

// File: rtl/cn_minsum_serial_if.sv
// v2c input stream and c2v output stream of one serial check node, plus status flags.
interface cn_minsum_serial_if;
    import ldpc_pkg::*;

    logic in_valid;
    logic in_ready;
    llr_t in_msg;
    logic in_last;
    logic out_valid;
    logic out_ready;
    llr_t out_msg;
    logic out_last;
    logic parity_ok;
    logic err_len;

    modport master (
        output in_valid, in_msg, in_last, out_ready,
        input  in_ready, out_valid, out_msg, out_last, parity_ok, err_len
    );

    modport slave (
        input  in_valid, in_msg, in_last, out_ready,
        output in_ready, out_valid, out_msg, out_last, parity_ok, err_len
    );
endinterface

// File: rtl/cn_min2_tracker.sv
// Running min1/min2/argmin over one check's magnitudes; updates on en_i, restarts when first_i.
// Next-state values are exported so the caller can use the final beat's result in the same cycle.
module cn_min2_tracker
    import ldpc_pkg::*;
#(
    parameter int DEG = 6,
    parameter int CW  = $clog2(DEG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          first_i,
    input  mag_t          mag_i,
    input  logic [CW-1:0] k_i,
    output mag_t          min1_o,
    output mag_t          min2_o,
    output logic [CW-1:0] idx_o,
    output mag_t          min1_nx_o,
    output mag_t          min2_nx_o,
    output logic [CW-1:0] idx_nx_o
);
    mag_t          min1_q, min2_q, min1_d, min2_d;
    logic [CW-1:0] idx_q, idx_d;

    // Strict compares keep the earlier index on ties.
    always_comb begin
        min1_d = first_i ? MAG_MAX : min1_q;
        min2_d = first_i ? MAG_MAX : min2_q;
        idx_d  = first_i ? '0 : idx_q;
        if (mag_i < min1_d) begin
            min2_d = min1_d;
            min1_d = mag_i;
            idx_d  = k_i;
        end else if (mag_i < min2_d) begin
            min2_d = mag_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            min1_q <= MAG_MAX;
            min2_q <= MAG_MAX;
            idx_q  <= '0;
        end else if (en_i) begin
            min1_q <= min1_d;
            min2_q <= min2_d;
            idx_q  <= idx_d;
        end
    end

    assign min1_o    = min1_q;
    assign min2_o    = min2_q;
    assign idx_o     = idx_q;
    assign min1_nx_o = min1_d;
    assign min2_nx_o = min2_d;
    assign idx_nx_o  = idx_d;
endmodule

// File: rtl/cn_minsum_serial.sv
// Serial offset-min-sum check node: DEG v2c beats in, DEG c2v beats out in order, first out 1 cycle after last in.
// Outputs are registered and held while out_ready is low; input is blocked during EMIT (1 bubble per check).
module cn_minsum_serial
    import ldpc_pkg::*;
#(
    parameter int   DEG    = 6,
    parameter mag_t OFFSET = OFFSET_DEF
) (
    input  logic               clk,
    input  logic               rst,
    cn_minsum_serial_if.slave  bus
);
    localparam int            CW   = $clog2(DEG);
    localparam logic [CW-1:0] LAST = CW'(DEG - 1);

    typedef enum logic {COLLECT, EMIT} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          sgn_q;
    logic [DEG-1:0] sign_vec_q;
    logic          err_q, in_ready_q, out_valid_q, out_last_q, parity_q;
    llr_t          out_msg_q;

    mag_t           mag, min1_q, min2_q, min1_nx, min2_nx, m1, m2;
    logic [CW-1:0]  idx_q, idx_nx, idx, j_nx;
    logic           msb, sgn_nx, sg, accept, fire;
    logic [DEG-1:0] svec_nx, sv;
    llr_t           nxt_msg;

    function automatic llr_t c2v(input mag_t m, input logic neg);
        mag_t mp;
        mp = (m > OFFSET) ? m - OFFSET : '0;
        return neg ? llr_t'(-mp) : llr_t'(mp);
    endfunction

    assign accept = bus.in_valid & in_ready_q;
    assign fire   = out_valid_q & bus.out_ready;

    cn_min2_tracker #(.DEG(DEG), .CW(CW)) u_trk (
        .clk       (clk),
        .rst       (rst),
        .en_i      (accept),
        .first_i   (cnt_q == '0),
        .mag_i     (mag),
        .k_i       (cnt_q),
        .min1_o    (min1_q),
        .min2_o    (min2_q),
        .idx_o     (idx_q),
        .min1_nx_o (min1_nx),
        .min2_nx_o (min2_nx),
        .idx_nx_o  (idx_nx)
    );

    // Beat 0 is built from the tracker's next state so it is ready the cycle after the last input.
    always_comb begin
        mag     = sat_abs(bus.in_msg);
        msb     = bus.in_msg[W-1];
        sgn_nx  = (cnt_q == '0) ? msb : (sgn_q ^ msb);
        svec_nx = sign_vec_q;
        svec_nx[cnt_q] = msb;
        if (state_q == COLLECT) begin
            j_nx = '0;
            m1   = min1_nx;
            m2   = min2_nx;
            idx  = idx_nx;
            sg   = sgn_nx;
            sv   = svec_nx;
        end else begin
            j_nx = cnt_q + CW'(1);
            m1   = min1_q;
            m2   = min2_q;
            idx  = idx_q;
            sg   = sgn_q;
            sv   = sign_vec_q;
        end
        nxt_msg = c2v((j_nx == idx) ? m2 : m1, sg ^ sv[j_nx]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            sgn_q       <= 1'b0;
            sign_vec_q  <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_msg_q   <= '0;
            out_last_q  <= 1'b0;
            parity_q    <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: if (accept) begin
                    sign_vec_q <= svec_nx;
                    sgn_q      <= sgn_nx;
                    if (bus.in_last != (cnt_q == LAST)) err_q <= 1'b1;
                    if (cnt_q == LAST) begin
                        state_q     <= EMIT;
                        cnt_q       <= '0;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_msg_q   <= nxt_msg;
                        out_last_q  <= (j_nx == LAST);
                        parity_q    <= ~sgn_nx;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                EMIT: if (fire) begin
                    if (cnt_q == LAST) begin
                        state_q     <= COLLECT;
                        cnt_q       <= '0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        out_msg_q   <= '0;
                        out_last_q  <= 1'b0;
                    end else begin
                        cnt_q      <= j_nx;
                        out_msg_q  <= nxt_msg;
                        out_last_q <= (j_nx == LAST);
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_msg   = out_msg_q;
    assign bus.out_last  = out_last_q;
    assign bus.parity_ok = parity_q;
    assign bus.err_len   = err_q;
endmodule

// File: tb/tb_cn_minsum_serial.sv
// Three check nodes (OFFSET 0, 0x80, 0x180) driven in lockstep; hand vectors plus random checks vs a reference model.
module tb_cn_minsum_serial;
    localparam int DEG = 6;

    typedef logic [DEG-1:0][15:0]       pvec_t;
    typedef logic [2:0][DEG-1:0][15:0]  pexp_t;
    typedef struct packed {
        pvec_t v;
        pexp_t e;
        logic  par;
    } row_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_last, out_ready;
    logic [15:0] in_msg;
    always #5 clk = ~clk;

    cn_minsum_serial_if b0 ();
    cn_minsum_serial_if b1 ();
    cn_minsum_serial_if b2 ();

    assign b0.in_valid = in_valid; assign b0.in_msg = in_msg; assign b0.in_last = in_last; assign b0.out_ready = out_ready;
    assign b1.in_valid = in_valid; assign b1.in_msg = in_msg; assign b1.in_last = in_last; assign b1.out_ready = out_ready;
    assign b2.in_valid = in_valid; assign b2.in_msg = in_msg; assign b2.in_last = in_last; assign b2.out_ready = out_ready;

    cn_minsum_serial #(.DEG(DEG), .OFFSET(16'h0000)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    cn_minsum_serial #(.DEG(DEG), .OFFSET(16'h0080)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    cn_minsum_serial #(.DEG(DEG), .OFFSET(16'h0180)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

    logic        i_rdy [3], o_vld [3], o_last [3], o_par [3], o_err [3];
    logic [15:0] o_msg [3];
    assign i_rdy[0] = b0.in_ready; assign o_vld[0] = b0.out_valid; assign o_last[0] = b0.out_last;
    assign o_par[0] = b0.parity_ok; assign o_err[0] = b0.err_len;   assign o_msg[0] = b0.out_msg;
    assign i_rdy[1] = b1.in_ready; assign o_vld[1] = b1.out_valid; assign o_last[1] = b1.out_last;
    assign o_par[1] = b1.parity_ok; assign o_err[1] = b1.err_len;   assign o_msg[1] = b1.out_msg;
    assign i_rdy[2] = b2.in_ready; assign o_vld[2] = b2.out_valid; assign o_last[2] = b2.out_last;
    assign o_par[2] = b2.parity_ok; assign o_err[2] = b2.err_len;   assign o_msg[2] = b2.out_msg;

    int vectors = 0;
    int miscompares = 0;
    bit exp_err = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int offs(input int d);
        return (d == 0) ? 0 : (d == 1) ? 128 : 384;
    endfunction

    function automatic pvec_t mk(input int a0, a1, a2, a3, a4, a5);
        pvec_t r;
        r[0] = 16'(a0); r[1] = 16'(a1); r[2] = 16'(a2);
        r[3] = 16'(a3); r[4] = 16'(a4); r[5] = 16'(a5);
        return r;
    endfunction

    // Reference: smallest magnitude excluding self, minus offset, signed by product of other signs.
    function automatic pvec_t model(input pvec_t v, input int off, output logic par);
        int mag [DEG];
        int val, i1, m1, m2, m;
        logic s, neg;
        pvec_t e;
        s = 1'b0;
        for (int k = 0; k < DEG; k++) begin
            val    = int'($signed(v[k]));
            mag[k] = (val < 0) ? -val : val;
            if (mag[k] > 32767) mag[k] = 32767;
            s ^= (val < 0);
        end
        i1 = 0;
        for (int k = 1; k < DEG; k++) if (mag[k] < mag[i1]) i1 = k;
        m1 = mag[i1];
        m2 = 32767;
        for (int k = 0; k < DEG; k++) if (k != i1 && mag[k] < m2) m2 = mag[k];
        for (int j = 0; j < DEG; j++) begin
            m    = (j == i1) ? m2 : m1;
            m    = (m > off) ? m - off : 0;
            neg  = s ^ (int'($signed(v[j])) < 0);
            e[j] = 16'(neg ? -m : m);
        end
        par = ~s;
        return e;
    endfunction

    task automatic send(input pvec_t v, input int last_pos, input int nbeats, input bit gaps);
        int t;
        for (int k = 0; k < nbeats; k++) begin
            if (gaps && ($urandom % 3 == 0)) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_msg   = v[k];
            in_last  = (k == last_pos);
            t = 0;
            while (!i_rdy[0] && t < 50) begin
                @(negedge clk);
                t++;
            end
            chk($sformatf("in_ready beat %0d", k), int'(i_rdy[0]), 1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s dut%0d out_valid", tag, d), int'(o_vld[d]), 0);
            chk($sformatf("%s dut%0d in_ready", tag, d), int'(i_rdy[d]), 1);
            chk($sformatf("%s dut%0d err_len", tag, d), int'(o_err[d]), int'(exp_err));
        end
    endtask

    task automatic run_check(input pvec_t v, input int last_pos, input pexp_t e, input logic par,
                             input bit stall, input bit rnd, input bit gaps);
        int j, t, st;
        bit acc;
        send(v, last_pos, DEG, gaps);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("latency dut%0d out_valid", d), int'(o_vld[d]), 1);
            chk($sformatf("latency dut%0d in_ready", d), int'(i_rdy[d]), 0);
        end
        j = 0; t = 0; st = 0;
        while (j < DEG && t < 500) begin
            if (stall && j == 2 && st < 5) begin
                out_ready = 1'b0;
                st++;
            end else begin
                out_ready = rnd ? 1'($urandom % 2) : 1'b1;
            end
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("dut%0d beat%0d out_valid", d, j), int'(o_vld[d]), 1);
                chk($sformatf("dut%0d beat%0d in_ready", d, j), int'(i_rdy[d]), 0);
                chk($sformatf("dut%0d beat%0d out_msg", d, j), int'($signed(o_msg[d])), int'($signed(e[d][j])));
                chk($sformatf("dut%0d beat%0d out_last", d, j), int'(o_last[d]), int'(j == DEG - 1));
                if (j == DEG - 1)
                    chk($sformatf("dut%0d parity_ok", d), int'(o_par[d]), int'(par));
            end
            acc = out_ready && o_vld[0];
            @(negedge clk);
            if (acc) j++;
            t++;
        end
        chk("c2v beats accepted", j, DEG);
        out_ready = 1'b0;
        check_idle("bubble");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_err = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset dut%0d out_msg", d), int'(o_msg[d]), 0);
            chk($sformatf("reset dut%0d out_last", d), int'(o_last[d]), 0);
            chk($sformatf("reset dut%0d parity_ok", d), int'(o_par[d]), 0);
        end
        check_idle("reset");
    endtask

    row_t rows [5];

    initial begin
        pvec_t v;
        pexp_t e;
        logic  par, p;
        logic [15:0] r;

        rows[0].v = mk(768, -256, 1280, 512, -1024, 1792);
        rows[0].e[0] = mk(256, -512, 256, 256, -256, 256);
        rows[0].e[1] = mk(128, -384, 128, 128, -128, 128);
        rows[0].e[2] = mk(0, -128, 0, 0, 0, 0);
        rows[0].par = 1'b1;
        rows[1].v = mk(256, 256, 256, 256, 256, 256);
        rows[1].e[0] = mk(256, 256, 256, 256, 256, 256);
        rows[1].e[1] = mk(128, 128, 128, 128, 128, 128);
        rows[1].e[2] = mk(0, 0, 0, 0, 0, 0);
        rows[1].par = 1'b1;
        rows[2].v = mk(-32768, 32767, 32767, 32767, 32767, 32767);
        rows[2].e[0] = mk(32767, -32767, -32767, -32767, -32767, -32767);
        rows[2].e[1] = mk(32639, -32639, -32639, -32639, -32639, -32639);
        rows[2].e[2] = mk(32383, -32383, -32383, -32383, -32383, -32383);
        rows[2].par = 1'b0;
        rows[3].v = mk(0, -300, 300, -300, 1000, -5000);
        rows[3].e[0] = mk(-300, 0, 0, 0, 0, 0);
        rows[3].e[1] = mk(-172, 0, 0, 0, 0, 0);
        rows[3].e[2] = mk(0, 0, 0, 0, 0, 0);
        rows[3].par = 1'b0;
        rows[4].v = mk(128, 129, -384, 385, 1000, 1000);
        rows[4].e[0] = mk(-129, -128, 128, -128, -128, -128);
        rows[4].e[1] = mk(-1, 0, 0, 0, 0, 0);
        rows[4].e[2] = mk(0, 0, 0, 0, 0, 0);
        rows[4].par = 1'b0;

        in_valid = 1'b0; in_last = 1'b0; in_msg = '0; out_ready = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);
        do_reset();

        for (int i = 0; i < 5; i++)
            run_check(rows[i].v, DEG - 1, rows[i].e, rows[i].par, i == 1, 1'b0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            for (int k = 0; k < DEG; k++) begin
                case ($urandom % 3)
                    0: r = 16'($urandom);
                    1: begin
                        r = 16'($urandom_range(0, 3) * 256);
                        if ($urandom % 2 == 1) r = -r;
                    end
                    default: r = ($urandom % 2 == 1) ? 16'h8000 : 16'($urandom_range(32000, 32767));
                endcase
                v[k] = r;
            end
            for (int d = 0; d < 3; d++) e[d] = model(v, offs(d), p);
            par = p;
            run_check(v, DEG - 1, e, par, n == 7, 1'b1, 1'b1);
        end

        exp_err = 1'b1;
        run_check(rows[0].v, 3, rows[0].e, rows[0].par, 1'b0, 1'b0, 1'b0);
        run_check(rows[1].v, DEG - 1, rows[1].e, rows[1].par, 1'b0, 1'b1, 1'b0);

        send(rows[2].v, DEG - 1, DEG, 1'b0);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        do_reset();

        send(rows[3].v, DEG - 1, 3, 1'b0);
        do_reset();
        run_check(rows[0].v, DEG - 1, rows[0].e, rows[0].par, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d miscompares %0d", vectors, miscompares);
        $fatal(1, "watchdog");
    end
endmodule
